// File: rtl/status_frame_rx.sv
// rtl/status_frame_rx.sv - motor status frame receiver: sync hunt, CRC-16/CCITT check, decode, stats
module status_frame_rx #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int TIMEOUT_CYCLES   = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        status_valid,
    output logic [7:0]  status_motor,
    output logic [31:0] status_enc0_pos,
    output logic [31:0] status_enc1_pos,
    output logic [31:0] status_enc0_vel,
    output logic [31:0] status_enc1_vel,
    output logic [31:0] status_error_code,
    output logic [15:0] good_frame_count,
    output logic [15:0] crc_error_count,
    output logic [15:0] drop_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        HUNT0,
        HUNT1,
        MOTOR,
        PAYLOAD,
        CRC_HI,
        CRC_LO
    } state_t;

    state_t         state, state_next;
    logic [15:0]    crc;
    logic [7:0]     crc_hi;
    logic [7:0]     motor_id;
    logic [4:0]     byte_cnt;
    logic [159:0]   payload;
    logic [TW-1:0]  timer;

    logic           crc_lo_byte;
    logic           crc_ok;
    logic           id_ok;
    logic           frame_good;
    logic           frame_crc_err;
    logic           frame_id_drop;
    logic           timeout;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        crc_lo_byte   = (state == CRC_LO) && rx_valid;
        crc_ok        = (crc == {crc_hi, rx_data});
        id_ok         = int'(motor_id) < NUMBER_OF_MOTORS;
        frame_good    = crc_lo_byte && crc_ok && id_ok;
        frame_crc_err = crc_lo_byte && !crc_ok;
        frame_id_drop = crc_lo_byte && crc_ok && !id_ok;
        timeout       = (state != HUNT0) && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = HUNT0;
        end else if (rx_valid) begin
            case (state)
                HUNT0:   if (rx_data == 8'hAA) state_next = HUNT1;
                HUNT1: begin
                    if (rx_data == 8'h55)      state_next = MOTOR;
                    else if (rx_data != 8'hAA) state_next = HUNT0;
                end
                MOTOR:   state_next = PAYLOAD;
                PAYLOAD: if (byte_cnt == 5'd19) state_next = CRC_HI;
                CRC_HI:  state_next = CRC_LO;
                CRC_LO:  state_next = HUNT0;
                default: state_next = HUNT0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT0;
        end else begin
            state <= state_next;
        end
    end

    // Frame datapath: CRC, byte counter, payload shift register and idle timer
    always_ff @(posedge clk) begin
        if (reset) begin
            crc      <= 16'hFFFF;
            crc_hi   <= 8'h00;
            motor_id <= 8'h00;
            byte_cnt <= 5'd0;
            payload  <= '0;
            timer    <= '0;
        end else begin
            if (state == HUNT0 || rx_valid) begin
                timer <= '0;
            end else if (!timeout) begin
                timer <= timer + TW'(1);
            end
            if (rx_valid) begin
                case (state)
                    MOTOR: begin
                        motor_id <= rx_data;
                        crc      <= crc16_byte(16'hFFFF, rx_data);
                        byte_cnt <= 5'd0;
                    end
                    PAYLOAD: begin
                        // byte i lands at bits [8i+7:8i] once all 20 are in, giving little-endian words
                        payload  <= {rx_data, payload[159:8]};
                        crc      <= crc16_byte(crc, rx_data);
                        byte_cnt <= byte_cnt + 5'd1;
                    end
                    CRC_HI: crc_hi <= rx_data;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_valid      <= 1'b0;
            status_motor      <= 8'h00;
            status_enc0_pos   <= 32'h0;
            status_enc1_pos   <= 32'h0;
            status_enc0_vel   <= 32'h0;
            status_enc1_vel   <= 32'h0;
            status_error_code <= 32'h0;
            good_frame_count  <= 16'h0;
            crc_error_count   <= 16'h0;
            drop_count        <= 16'h0;
        end else begin
            status_valid <= frame_good;
            if (frame_good) begin
                status_motor      <= motor_id;
                status_enc0_pos   <= payload[31:0];
                status_enc1_pos   <= payload[63:32];
                status_enc0_vel   <= payload[95:64];
                status_enc1_vel   <= payload[127:96];
                status_error_code <= payload[159:128];
                good_frame_count  <= sat_inc(good_frame_count);
            end
            if (frame_crc_err) begin
                crc_error_count <= sat_inc(crc_error_count);
            end
            if (frame_id_drop || timeout) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

endmodule

// File: doc/status_frame_rx.md
STATUS_FRAME_RX -- requirements
Module: status_frame_rx

Interface
REQ-001 SHALL have parameter NUMBER_OF_MOTORS, default 6, number of valid motor ids (0..NUMBER_OF_MOTORS-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum idle clock cycles allowed between bytes of one frame.
REQ-003 SHALL have port clk  in  1  system clock; single clock domain.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  in  8  received UART byte.
REQ-006 SHALL have port rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
REQ-007 SHALL have port status_valid  out  1  one-cycle pulse; all status_* outputs carry a new good frame.
REQ-008 SHALL have port status_motor  out  8  motor id of the frame.
REQ-009 SHALL have ports status_enc0_pos, status_enc1_pos, status_enc0_vel, status_enc1_vel  out  32 each, signed encoder data.
REQ-010 SHALL have port status_error_code  out  32  motor board error word.
REQ-011 SHALL have port good_frame_count  out  16  count of accepted frames.
REQ-012 SHALL have port crc_error_count  out  16  count of frames dropped on CRC mismatch.
REQ-013 SHALL have port drop_count  out  16  count of frames dropped on bad motor id or timeout.

Function
REQ-014 SHALL parse frame: 0xAA, 0x55, motor id, 20 payload bytes, CRC high byte, CRC low byte (25 bytes total).
REQ-015 SHALL decode payload as 5 little-endian 32-bit words in order: enc0_pos, enc1_pos, enc0_vel, enc1_vel, error_code.
REQ-016 SHALL use CRC-16/CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) over motor id and payload (21 bytes); update CRC one byte per accepted rx_valid.
REQ-017 SHALL implement states HUNT0, HUNT1, MOTOR, PAYLOAD, CRC_HI, CRC_LO; advance only on rx_valid.
REQ-018 HUNT0: 0xAA -> HUNT1; else stay.
REQ-019 HUNT1: 0x55 -> MOTOR; 0xAA -> stay HUNT1; else -> HUNT0.
REQ-020 MOTOR: latch id, reset CRC and byte counter -> PAYLOAD; PAYLOAD after 20th byte -> CRC_HI; CRC_HI -> CRC_LO; CRC_LO -> HUNT0.
REQ-021 On the CRC_LO byte: CRC match and id < NUMBER_OF_MOTORS -> update status_* registers and pulse status_valid the next cycle; increment good_frame_count.
REQ-022 CRC mismatch -> no status update; increment crc_error_count (CRC check takes precedence over id check).
REQ-023 CRC match with id >= NUMBER_OF_MOTORS -> no status update; increment drop_count.
REQ-024 status_* registers SHALL hold the last good frame; a partial or bad frame never changes them.
REQ-025 Idle timer counts cycles without rx_valid in any state other than HUNT0; reaching TIMEOUT_CYCLES -> HUNT0, increment drop_count once.
REQ-026 Timer SHALL reset on every rx_valid and in HUNT0.
REQ-027 Counters SHALL saturate at 0xFFFF; no wrap.
REQ-028 Latency SHALL be exactly 1 cycle from the rx_valid of the final CRC byte to status_valid.
REQ-029 Back-to-back frames SHALL be accepted: a 0xAA arriving the cycle after the CRC_LO byte SHALL be taken by HUNT0.
REQ-030 rx_valid SHALL be accepted every cycle; no backpressure.

Reset
REQ-031 On reset, state HUNT0; CRC 0xFFFF; timer, byte counter and all counters 0; status_valid 0; status_motor and all 32-bit status outputs 0.
REQ-032 Reset mid-frame SHALL discard the partial frame with no counter change; parsing resumes at HUNT0 on the cycle after reset deasserts.

Verification
REQ-033 Good frame for id 2, enc0_pos=0x00001234, enc1_pos=0xFFFFFFFE, vel 5/-5, error 0, correct CRC from bench model -> status_valid 1 cycle after last byte, fields match, good_frame_count=1.
REQ-034 Same frame with last CRC byte XOR 0x01 -> no status_valid, outputs unchanged, crc_error_count=1.
REQ-035 Valid-CRC frame with id 6 (NUMBER_OF_MOTORS=6) -> no status_valid, drop_count=1.
REQ-036 Send header and 10 payload bytes, then idle TIMEOUT_CYCLES -> return to HUNT0, drop_count=1; a following good frame is accepted.
REQ-037 Byte stream 0xAA 0xAA 0x55 then a good frame body, followed immediately by a second good frame -> two status_valid pulses, good_frame_count=2.
REQ-038 Assert reset after byte 12 of a frame, then send a good frame -> counters all 0 before the good frame, exactly one status_valid after it.
